// File: rtl/mem_cache_pkg.sv
// ============================================================================
// Module      : mem_cache_pkg
// Description : Shared geometry, FSM state encoding, cache line type and a
//               word-select helper for the 2-way MEM-stage data cache.
//               Optional feature macro used by the cache: CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_cache_pkg;

    localparam int SETS     = 64;
    localparam int TAG_W    = 10;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int OFFSET_W = 3;            // 8-byte (two-word) lines

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } line_t;

    // Word 0 lives in the low half of a line.
    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic sel);
        return sel ? line[63:32] : line[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_set_array.sv
// ============================================================================
// Module      : cache_set_array
// Description : Storage for both ways (valid/tag/data) plus one LRU bit per
//               set. Combinational read of the addressed set, synchronous
//               line fill / word write, synchronous clear of valid and LRU.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_set_array
    import mem_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_index,
    input  logic               i_way,
    input  logic               i_fill_en,
    input  logic [TAG_W-1:0]   i_fill_tag,
    input  logic [63:0]        i_fill_data,
    input  logic               i_word_we,
    input  logic               i_word_sel,
    input  logic [31:0]        i_word_data,
    input  logic               i_lru_we,
    input  logic               i_lru_val,
    output line_t              o_line0,
    output line_t              o_line1,
    output logic               o_lru
);

    line_t           w_line [2];
    logic [SETS-1:0] r_lru;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_way
            logic [SETS-1:0]  r_valid;
            logic [TAG_W-1:0] r_tag  [SETS];
            logic [63:0]      r_data [SETS];
            logic             w_sel;

            assign w_sel = (g == 0) ? ~i_way : i_way;

            // Valid bits: cleared on reset, set by a line fill.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                end else if (i_fill_en && w_sel) begin
                    r_valid[i_index] <= 1'b1;
                end
            end

            // Tag/data: whole-line fill on a miss, single-word update on a store hit.
            always_ff @(posedge clk) begin
                if (i_fill_en && w_sel) begin
                    r_tag[i_index]  <= i_fill_tag;
                    r_data[i_index] <= i_fill_data;
                end else if (i_word_we && w_sel) begin
                    if (i_word_sel) begin
                        r_data[i_index][63:32] <= i_word_data;
                    end else begin
                        r_data[i_index][31:0]  <= i_word_data;
                    end
                end
            end

            assign w_line[g] = '{valid: r_valid[i_index],
                                 tag:   r_tag[i_index],
                                 data:  r_data[i_index]};
        end
    endgenerate

    // LRU bit names the way to replace next in each set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lru <= '0;
        end else if (i_lru_we) begin
            r_lru[i_index] <= i_lru_val;
        end
    end

    assign o_line0 = w_line[0];
    assign o_line1 = w_line[1];
    assign o_lru   = r_lru[i_index];

endmodule

`default_nettype wire

// File: rtl/mem_cache_ctrl.sv
// ============================================================================
// Module      : mem_cache_ctrl
// Description : 2-way set-associative, write-through / no-write-allocate data
//               cache between the MEM stage and the SRAM controller. Read
//               hits complete in the same cycle; misses fetch a 64-bit line.
//               Define CACHE_STATS_EN to add hit_count / miss_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_cache_ctrl
    import mem_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_tag_lsb = OFFSET_W + INDEX_W;
    localparam int c_tag_end = c_tag_lsb + TAG_W;

    state_t       r_state;
    logic [31:0]  r_req_addr;       // captured request address; also drives sram_address
    logic [31:0]  r_sram_wdata;
    logic         r_sram_read_en;
    logic         r_sram_write_en;
    logic [31:0]  r_read_data;      // last load result, held between loads

`ifdef CACHE_STATS_EN
    logic [31:0]  r_hit_count;
    logic [31:0]  r_miss_count;
`endif

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_req_tag;
    line_t              w_line0;
    line_t              w_line1;
    logic               w_lru;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim;
    logic               w_fill_en;
    logic [31:0]        w_hit_word;
    logic [31:0]        w_fill_word;
    logic               w_ready;
    logic [31:0]        w_read_data;
    logic               w_way;
    logic               w_word_we;
    logic               w_lru_we;
    logic               w_lru_val;
    logic [33-c_tag_end:0] w_unused_addr;

    // While a miss is outstanding the array is addressed by the captured
    // address so the fill lands correctly even if the requester drops away.
    assign w_index   = (r_state == RD_MISS) ? r_req_addr[OFFSET_W +: INDEX_W]
                                            : address[OFFSET_W +: INDEX_W];
    assign w_req_tag = address[c_tag_lsb +: TAG_W];

    assign w_hit0    = w_line0.valid && (w_line0.tag == w_req_tag);
    assign w_hit1    = w_line1.valid && (w_line1.tag == w_req_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = w_hit1;
    assign w_hit_word  = sel_word(w_hit1 ? w_line1.data : w_line0.data, address[2]);
    assign w_fill_word = sel_word(sram_rdata, r_req_addr[2]);

    // Prefer an empty way (way 0 first); otherwise replace the LRU way.
    assign w_victim  = !w_line0.valid ? 1'b0 :
                       !w_line1.valid ? 1'b1 : w_lru;
    assign w_fill_en = (r_state == RD_MISS) && sram_ready;

    assign w_unused_addr = {address[31:c_tag_end], address[1:0]};

    // Handshake, load data mux and array update controls for the current cycle.
    always_comb begin
        w_ready     = 1'b1;
        w_read_data = r_read_data;
        w_way       = 1'b0;
        w_word_we   = 1'b0;
        w_lru_we    = 1'b0;
        w_lru_val   = 1'b0;
        case (r_state)
            IDLE: begin
                if (write_en) begin
                    w_ready = 1'b0;
                    if (w_hit) begin
                        w_way     = w_hit_way;
                        w_word_we = 1'b1;
                        w_lru_we  = 1'b1;
                        w_lru_val = ~w_hit_way;
                    end
                end else if (read_en) begin
                    if (w_hit) begin
                        w_read_data = w_hit_word;
                        w_lru_we    = 1'b1;
                        w_lru_val   = ~w_hit_way;
                    end else begin
                        w_ready = 1'b0;
                    end
                end
            end
            RD_MISS: begin
                w_ready = sram_ready;
                w_way   = w_victim;
                if (sram_ready) begin
                    w_read_data = w_fill_word;
                    w_lru_we    = 1'b1;
                    w_lru_val   = ~w_victim;
                end
            end
            WR_THRU: begin
                w_ready = sram_ready;
            end
            default: begin
                w_ready = 1'b1;
            end
        endcase
    end

    cache_set_array u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_way       (w_way),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (r_req_addr[c_tag_lsb +: TAG_W]),
        .i_fill_data (sram_rdata),
        .i_word_we   (w_word_we),
        .i_word_sel  (address[2]),
        .i_word_data (write_data),
        .i_lru_we    (w_lru_we),
        .i_lru_val   (w_lru_val),
        .o_line0     (w_line0),
        .o_line1     (w_line1),
        .o_lru       (w_lru)
    );

    // Control FSM: launches SRAM line reads / word writes and holds them until sram_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req_addr      <= '0;
            r_sram_wdata    <= '0;
            r_sram_read_en  <= 1'b0;
            r_sram_write_en <= 1'b0;
            r_read_data     <= '0;
`ifdef CACHE_STATS_EN
            r_hit_count     <= '0;
            r_miss_count    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_en) begin
                        r_req_addr      <= address;
                        r_sram_wdata    <= write_data;
                        r_sram_write_en <= 1'b1;
                        r_state         <= WR_THRU;
                    end else if (read_en) begin
                        if (w_hit) begin
                            r_read_data <= w_hit_word;
`ifdef CACHE_STATS_EN
                            r_hit_count <= r_hit_count + 32'd1;
`endif
                        end else begin
                            r_req_addr     <= address;
                            r_sram_read_en <= 1'b1;
                            r_state        <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        r_sram_read_en <= 1'b0;
                        r_read_data    <= w_fill_word;
`ifdef CACHE_STATS_EN
                        r_miss_count   <= r_miss_count + 32'd1;
`endif
                        r_state        <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (sram_ready) begin
                        r_sram_write_en <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign read_data     = w_read_data;
    assign ready         = w_ready;
    assign sram_read_en  = r_sram_read_en;
    assign sram_write_en = r_sram_write_en;
    assign sram_address  = r_req_addr;
    assign sram_wdata    = r_sram_wdata;

`ifdef CACHE_STATS_EN
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_cache_ctrl.sv
// ============================================================================
// Module      : tb_mem_cache_ctrl
// Description : Scoreboard bench for mem_cache_ctrl. Directed requests push
//               their expected completion into a queue; a monitor pops and
//               compares whenever the cache reports a completed request.
//               A behavioural SRAM controller answers line reads and stores.
//               Honours CACHE_STATS_EN when the RTL is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    mem_cache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .read_en       (read_en),
        .write_en      (write_en),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .ready         (ready),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_address  (sram_address),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .sram_ready    (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
        bit          exp_miss;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sram_mem [int unsigned];
    bit          seen_rd  = 1'b0;
    bit          seen_wr  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return 32'h5A00_0000 ^ a;
    endfunction

    // SRAM controller model: fixed 2-cycle latency, 1-cycle sram_ready pulse, reset-aware.
    initial begin : sram_model
        bit          is_wr;
        bit          abort;
        logic [31:0] a;
        logic [31:0] d;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && (sram_read_en || sram_write_en)) begin
                is_wr = sram_write_en;
                a     = sram_address;
                d     = sram_wdata;
                abort = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    if (rst) abort = 1'b1;
                end
                if (!abort) begin
                    #1;
                    if (is_wr) sram_mem[a] = d;
                    else sram_rdata = {mem_word((a & 32'hFFFF_FFF8) + 32'd4),
                                       mem_word(a & 32'hFFFF_FFF8)};
                    sram_ready = 1'b1;
                    @(posedge clk);
                    #1 sram_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: on every completed request pop the expectation and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_rd = 1'b0;
                seen_wr = 1'b0;
            end else begin
                if (sram_read_en)  seen_rd = 1'b1;
                if (sram_write_en) seen_wr = 1'b1;
                if (ready && (read_en || write_en)) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.is_write) begin
                            chk({e.name, "_sram_write"}, {31'd0, seen_wr}, 32'd1);
                            chk({e.name, "_no_line_read"}, {31'd0, seen_rd}, 32'd0);
                        end else begin
                            chk({e.name, "_data"}, read_data, e.data);
                            chk({e.name, "_missed"}, {31'd0, seen_rd}, {31'd0, e.exp_miss});
                        end
                    end
                    seen_rd = 1'b0;
                    seen_wr = 1'b0;
                end
            end
        end
    end

    task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input bit miss, input string nm);
        exp_t e;
        bit   done;
        e.is_write = wr;
        e.data     = exp;
        e.exp_miss = miss;
        e.name     = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        read_en    = !wr;
        write_en   = wr;
        address    = a;
        write_data = wd;
        done       = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;
        sram_mem[32'h40] = 32'h1111_1111;
        sram_mem[32'h44] = 32'h2222_2222;
        rst        = 1'b1;
        read_en    = 1'b0;
        write_en   = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",         {31'd0, ready},         32'd1);
        chk("reset_sram_read_en",  {31'd0, sram_read_en},  32'd0);
        chk("reset_sram_write_en", {31'd0, sram_write_en}, 32'd0);
        chk("reset_read_data",     read_data,              32'd0);

        // Cold miss then same-line hit on the other word.
        req(1'b0, 32'h0000_0040, '0, 32'h1111_1111, 1'b1, "t1_miss_0x40");
        req(1'b0, 32'h0000_0044, '0, 32'h2222_2222, 1'b0, "t2_hit_0x44");
`ifdef CACHE_STATS_EN
        @(negedge clk);
        chk("stats_hit_count",  hit_count,  32'd1);
        chk("stats_miss_count", miss_count, 32'd1);
`endif

        // Write-through store hit updates the cached word.
        req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, '0, 1'b0, "t3_write_hit");
        req(1'b0, 32'h0000_0040, '0, 32'hDEAD_BEEF, 1'b0, "t3_read_after_write");

        // Three tags in set 8: 0x240 becomes LRU and is evicted by 0x440.
        req(1'b0, 32'h0000_0240, '0, 32'h5A00_0240, 1'b1, "t4_fill_0x240");
        req(1'b0, 32'h0000_0040, '0, 32'hDEAD_BEEF, 1'b0, "t4_touch_0x40");
        req(1'b0, 32'h0000_0440, '0, 32'h5A00_0440, 1'b1, "t4_fill_0x440");
        req(1'b0, 32'h0000_0040, '0, 32'hDEAD_BEEF, 1'b0, "t4_0x40_still_hits");
        req(1'b0, 32'h0000_0240, '0, 32'h5A00_0240, 1'b1, "t4_0x240_evicted");
        req(1'b0, 32'h0000_0244, '0, 32'h5A00_0244, 1'b0, "t4_0x244_hit_word1");

        // Store miss does not allocate.
        req(1'b1, 32'h0000_0800, 32'h1234_5678, '0, 1'b0, "t5_write_miss");
        req(1'b0, 32'h0000_0800, '0, 32'h1234_5678, 1'b1, "t5_read_0x800_misses");

        // Reset in the middle of a miss.
        @(posedge clk);
        #1;
        read_en = 1'b1;
        address = 32'h0000_1000;
        seen    = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (sram_read_en) seen = 1'b1;
        end
        chk("t6_miss_started", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        read_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after_rst",        {31'd0, ready},        32'd1);
        chk("t6_sram_read_en_after_rst", {31'd0, sram_read_en}, 32'd0);
        req(1'b0, 32'h0000_0040, '0, 32'hDEAD_BEEF, 1'b1, "t6_0x40_misses_after_rst");
        req(1'b0, 32'h0000_0044, '0, 32'h2222_2222, 1'b0, "t6_0x44_hit_after_refill");

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
